// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RTYPE single-cycle datapath.
//   XLEN / NREGS / REG_AW : architectural data width, register count, and
//                           register address width
//   reg_addr_t / word_t   : register address and data word types
//   alu_op_t              : ALU operation encoding, shared by decoder and ALU
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

endpackage

// File: rtl/reg_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
// One combinational read port of the integer register file.
//   i_addr     : register address to read
//   i_storage  : the full register array
//   i_wr_en    : write-port enable (already qualified by reset in the top)
//   i_wr_addr  : write-port address
//   i_wr_data  : write-port data, forwarded when BYPASS != 0 and addresses hit
//   o_data     : read data; address 0 always reads zero
// ----------------------------------------------------------------------------
module reg_read_port
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int BYPASS = 0
) (
  input  logic [$clog2(NREGS)-1:0] i_addr,
  input  logic [XLEN-1:0]          i_storage [NREGS],
  input  logic                     i_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_wr_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  output logic [XLEN-1:0]          o_data
);

  // x0 is forced to zero ahead of the bypass check, so a write to x0 can never
  // leak through; a non-zero i_addr matching i_wr_addr implies wr_addr != 0.
  always_comb begin
    o_data = i_storage[i_addr];
    if (i_addr == '0) begin
      o_data = '0;
    end else if ((BYPASS != 0) && i_wr_en && (i_addr == i_wr_addr)) begin
      o_data = i_wr_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// Integer register file: NREGS x XLEN registers, x0 hardwired to zero.
// Two combinational operand read ports, one synchronous write port and one
// debug read port that never forwards write data.
//   clk       : clock, writes on rising edge
//   rst_n     : asynchronous active-low reset, clears all registers
//   rs1_addr  : read port 1 address      rs1_data : read port 1 data
//   rs2_addr  : read port 2 address      rs2_data : read port 2 data
//   wr_en     : write enable (reg_write)
//   wr_addr   : write address (rd)
//   wr_data   : write data (ALU result)
//   dbg_addr  : debug read address       dbg_data : debug read data
// BYPASS=1 forwards same-cycle write data to rs1/rs2. In a single-cycle
// datapath this closes a combinational loop through the ALU, so that top uses
// BYPASS=0; BYPASS=1 is intended for a registered write-back.
// ----------------------------------------------------------------------------
module reg_file
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_act;
  logic            w_wr_hit;

  // Qualifying with rst_n keeps forwarded data off the read ports while
  // reset is held, so every output reads zero during reset.
  assign w_wr_act = wr_en && rst_n;
  assign w_wr_hit = w_wr_en_nz(wr_en, wr_addr);

  function automatic logic w_wr_en_nz(input logic en,
                                      input logic [$clog2(NREGS)-1:0] addr);
    return en && (addr != '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_rs1 (
    .i_addr    (rs1_addr),
    .i_storage (r_regs),
    .i_wr_en   (w_wr_act),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_data    (rs1_data)
  );

  reg_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_rs2 (
    .i_addr    (rs2_addr),
    .i_storage (r_regs),
    .i_wr_en   (w_wr_act),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_data    (rs2_data)
  );

  // Debug port observes committed state only.
  reg_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (0)
  ) u_dbg (
    .i_addr    (dbg_addr),
    .i_storage (r_regs),
    .i_wr_en   (1'b0),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_data    (dbg_data)
  );

endmodule
